// File: rtl/cv32e40p_pkg.sv
// Shared constants for the cv32e40p instruction-side blocks.
// Master IDs stored in the arbiter's owner FIFO and the lock state encoding.
package cv32e40p_pkg;

  localparam logic INSTR_MASTER_PF  = 1'b0;
  localparam logic INSTR_MASTER_SEC = 1'b1;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_lock_e;

endpackage

// File: rtl/cv32e40p_fifo.sv
// Small synchronous FIFO with an occupancy count.
// It accepts a push and a pop together when full, and supports flush and setback.
module cv32e40p_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned FALL_THROUGH = 0,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  flush_but_first_i,
  input  logic                  setback_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      cnt_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_rptr;
  logic [ADDR_W-1:0]     r_wptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_bypass;
  logic                  w_doPush;
  logic                  w_doPop;
  logic                  w_normal;

  function automatic logic [ADDR_W-1:0] ptrNext(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] ptrPrev(input logic [ADDR_W-1:0] p);
    return (p == '0) ? ADDR_W'(DEPTH - 1) : p - 1'b1;
  endfunction

  // In fall-through mode an empty FIFO hands data_i straight to the reader.
  assign w_bypass = (FALL_THROUGH != 0) && (r_cnt == '0) && push_i;
  assign w_doPush = push_i && !(w_bypass && pop_i);
  assign w_doPop  = pop_i && (r_cnt != '0);
  assign w_normal = !flush_i && !flush_but_first_i && !setback_i;

  assign full_o  = (r_cnt == CNT_W'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign cnt_o   = r_cnt;
  assign data_o  = w_bypass ? data_i : r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_normal && w_doPush) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (flush_but_first_i) begin
      if (r_cnt != '0) begin
        r_wptr <= ptrNext(r_rptr);
        r_cnt  <= CNT_W'(1);
      end
    end else if (setback_i) begin
      if (r_cnt != '0) begin
        r_wptr <= ptrPrev(r_wptr);
        r_cnt  <= r_cnt - 1'b1;
      end
    end else begin
      if (w_doPush) r_wptr <= ptrNext(r_wptr);
      if (w_doPop)  r_rptr <= ptrNext(r_rptr);
      if (w_doPush && !w_doPop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_doPush && w_doPop) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/cv32e40p_instr_bus_arbiter.sv
// Round-robin arbiter sharing the OBI instruction port between the prefetcher and a
// secondary requester. Responses are routed to their owners in grant order.
module cv32e40p_instr_bus_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_lock_e        r_lock;
  arb_lock_e        w_lockNext;
  logic             r_lockSel;
  logic             r_last;
  logic [1:0]       w_req;
  logic             w_sel;
  logic             w_push;
  logic             w_pop;
  logic             w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_cnt;

  assign w_req = {m1_req_i, m0_req_i};

  always_comb begin
    w_sel = r_last;
    if (r_lock == ARB_LOCKED) begin
      w_sel = r_lockSel;
    end else begin
      case (w_req)
        2'b01:   w_sel = INSTR_MASTER_PF;
        2'b10:   w_sel = INSTR_MASTER_SEC;
        2'b11:   w_sel = ~r_last;
        default: w_sel = r_last;
      endcase
    end
  end

  // Full is judged on the registered count only, so rvalid never reaches req.
  assign instr_req_o  = w_req[w_sel] && !w_full;
  assign instr_addr_o = w_sel ? m1_addr_i : m0_addr_i;
  assign m0_gnt_o     = instr_req_o && instr_gnt_i && (w_sel == INSTR_MASTER_PF);
  assign m1_gnt_o     = instr_req_o && instr_gnt_i && (w_sel == INSTR_MASTER_SEC);

  assign w_push = instr_req_o && instr_gnt_i;
  assign w_pop  = instr_rvalid_i && !w_empty;

  assign m0_rvalid_o = w_pop && (w_head == INSTR_MASTER_PF);
  assign m1_rvalid_o = w_pop && (w_head == INSTR_MASTER_SEC);
  assign m0_rdata_o  = instr_rdata_i;
  assign m1_rdata_o  = instr_rdata_i;
  assign m0_err_o    = m0_rvalid_o && instr_err_i;
  assign m1_err_o    = m1_rvalid_o && instr_err_i;
  assign busy_o      = (w_cnt != '0);

  always_comb begin
    w_lockNext = r_lock;
    if (instr_req_o) w_lockNext = instr_gnt_i ? ARB_FREE : ARB_LOCKED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock    <= ARB_FREE;
      r_lockSel <= INSTR_MASTER_PF;
      r_last    <= INSTR_MASTER_SEC;
    end else begin
      r_lock <= w_lockNext;
      if (instr_req_o && !instr_gnt_i) r_lockSel <= w_sel;
      if (w_push) r_last <= w_sel;
    end
  end

  cv32e40p_fifo #(
    .DATA_WIDTH   (1),
    .DEPTH        (MAX_OUTSTANDING),
    .FALL_THROUGH (0)
  ) u_ownerFifo (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (1'b0),
    .flush_but_first_i (1'b0),
    .setback_i         (1'b0),
    .full_o            (w_full),
    .empty_o           (w_empty),
    .cnt_o             (w_cnt),
    .data_i            (w_sel),
    .push_i            (w_push),
    .data_o            (w_head),
    .pop_i             (w_pop)
  );

`ifdef CV32E40P_ASSERT_ON
  assertNoSpuriousRvalid: assert property (@(posedge clk) disable iff (!rst_n)
    instr_rvalid_i |-> (w_cnt != '0))
    else $error("rvalid received with no outstanding transaction");

  assertAddrStableLocked: assert property (@(posedge clk) disable iff (!rst_n)
    (r_lock == ARB_LOCKED) |-> $stable(instr_addr_o))
    else $error("instr_addr_o changed while request locked");

  assertAddrAligned: assert property (@(posedge clk) disable iff (!rst_n)
    instr_req_o |-> (instr_addr_o[1:0] == 2'b00))
    else $error("instr_addr_o not word aligned");
`endif

endmodule

// File: tb/tb_cv32e40p_instr_bus_arbiter.sv
// Directed bench for the instruction bus arbiter: a per-cycle vector table
// followed by a hand-written mid-operation reset sequence.
module tb_cv32e40p_instr_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0Req, m1Req, gnt, rvalid, err;
  logic [31:0] m0Addr, m1Addr, rdata;
  logic        m0Gnt, m1Gnt, m0Rvalid, m1Rvalid, m0Err, m1Err;
  logic [31:0] m0Rdata, m1Rdata, addrOut;
  logic        reqOut, busy;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic        m0r, m1r, gnt, rv;
    logic [31:0] data;
    logic        err;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eG0, eG1, eRv0, eRv1, eErr0, eErr1, eBusy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  cv32e40p_instr_bus_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_req_i       (m0Req),
    .m0_addr_i      (m0Addr),
    .m0_gnt_o       (m0Gnt),
    .m0_rvalid_o    (m0Rvalid),
    .m0_rdata_o     (m0Rdata),
    .m0_err_o       (m0Err),
    .m1_req_i       (m1Req),
    .m1_addr_i      (m1Addr),
    .m1_gnt_o       (m1Gnt),
    .m1_rvalid_o    (m1Rvalid),
    .m1_rdata_o     (m1Rdata),
    .m1_err_o       (m1Err),
    .instr_req_o    (reqOut),
    .instr_gnt_i    (gnt),
    .instr_addr_o   (addrOut),
    .instr_rvalid_i (rvalid),
    .instr_rdata_i  (rdata),
    .instr_err_i    (err),
    .busy_o         (busy)
  );

  task automatic addVec(input logic m0r, m1r, g, rv, input logic [31:0] d, input logic e,
                        input logic eReq, input logic [31:0] eAddr,
                        input logic eG0, eG1, eRv0, eRv1, eErr0, eErr1, eBusy);
    vec_t v;
    v.m0r = m0r; v.m1r = m1r; v.gnt = g; v.rv = rv; v.data = d; v.err = e;
    v.eReq = eReq; v.eAddr = eAddr; v.eG0 = eG0; v.eG1 = eG1;
    v.eRv0 = eRv0; v.eRv1 = eRv1; v.eErr0 = eErr0; v.eErr1 = eErr1; v.eBusy = eBusy;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic m0r, m1r, g, rv, input logic [31:0] d, input logic e);
    m0Req  = m0r;
    m1Req  = m1r;
    gnt    = g;
    rvalid = rv;
    rdata  = d;
    err    = e;
  endtask

  // Address is compared only when a downstream request is expected.
  task automatic checkOutput(input string name, input logic eReq, input logic [31:0] eAddr,
                             input logic eG0, eG1, eRv0, eRv1, eErr0, eErr1, eBusy,
                             input logic [31:0] eData);
    logic [8:0]  gotCtl, expCtl;
    logic [31:0] gotAddr;
    gotCtl  = {reqOut, m0Gnt, m1Gnt, m0Rvalid, m1Rvalid, m0Err, m1Err, busy, 1'b0};
    expCtl  = {eReq, eG0, eG1, eRv0, eRv1, eErr0, eErr1, eBusy, 1'b0};
    gotAddr = eReq ? addrOut : eAddr;
    nChecks++;
    if (gotCtl !== expCtl || gotAddr !== eAddr || m0Rdata !== eData || m1Rdata !== eData) begin
      nFails++;
      $display("[TB] FAIL %s: got req,g0,g1,rv0,rv1,e0,e1,busy=%b addr=%h rd0=%h rd1=%h required %b addr=%h rd=%h",
               name, gotCtl[8:1], gotAddr, m0Rdata, m1Rdata, expCtl[8:1], eAddr, eData);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    m0Addr = 32'h100;
    m1Addr = 32'h200;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);

    //     m0r m1r gnt rv data          err  req addr    g0 g1 rv0 rv1 e0 e1 busy
    addVec(1, 1, 1, 0, 32'h0,        0,   1, 32'h100, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 1, 1, 32'hA0A0A0A0, 0,   1, 32'h200, 0, 1, 1, 0, 0, 0, 1);
    addVec(1, 1, 1, 1, 32'hB0B0B0B0, 0,   1, 32'h100, 1, 0, 0, 1, 0, 0, 1);
    addVec(1, 1, 1, 1, 32'hC0C0C0C0, 1,   1, 32'h200, 0, 1, 1, 0, 1, 0, 1);
    addVec(0, 0, 0, 1, 32'hD0D0D0D0, 0,   0, 32'h0,   0, 0, 0, 1, 0, 0, 1);
    addVec(0, 0, 0, 0, 32'h0,        0,   0, 32'h0,   0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 32'h0,        0,   1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 32'h0,        0,   1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 1, 0, 32'h0,        0,   1, 32'h200, 0, 1, 0, 0, 0, 0, 0);
    addVec(1, 1, 1, 0, 32'h0,        0,   1, 32'h100, 1, 0, 0, 0, 0, 0, 1);
    addVec(1, 1, 1, 0, 32'h0,        0,   0, 32'h0,   0, 0, 0, 0, 0, 0, 1);
    addVec(1, 1, 1, 1, 32'hDEADBEEF, 0,   0, 32'h0,   0, 0, 0, 1, 0, 0, 1);
    addVec(1, 1, 1, 0, 32'h0,        0,   1, 32'h200, 0, 1, 0, 0, 0, 0, 1);
    addVec(1, 1, 1, 1, 32'hE0E0E0E0, 0,   0, 32'h0,   0, 0, 1, 0, 0, 0, 1);
    addVec(1, 0, 1, 1, 32'hF0F0F0F0, 0,   1, 32'h100, 1, 0, 0, 1, 0, 0, 1);
    addVec(0, 0, 0, 1, 32'h12345678, 0,   0, 32'h0,   0, 0, 1, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 32'h87654321, 1,   0, 32'h0,   0, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 1, 0, 32'h0,        0,   1, 32'h100, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 1, 0, 32'h0,        0,   1, 32'h100, 1, 0, 0, 0, 0, 0, 1);
    addVec(1, 0, 1, 0, 32'h0,        0,   0, 32'h0,   0, 0, 0, 0, 0, 0, 1);
    addVec(1, 0, 0, 1, 32'hDEADBEEF, 0,   0, 32'h0,   0, 0, 1, 0, 0, 0, 1);
    addVec(1, 0, 0, 0, 32'h0,        0,   1, 32'h100, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 0, 1, 0, 32'h0,        0,   1, 32'h100, 1, 0, 0, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 32'h11111111, 0,   0, 32'h0,   0, 0, 1, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 32'h22222222, 0,   0, 32'h0,   0, 0, 1, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 32'h0,        0,   0, 32'h0,   0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    checkOutput("inReset", 1'b0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].m0r, vecs[i].m1r, vecs[i].gnt, vecs[i].rv, vecs[i].data, vecs[i].err);
      #2;
      checkOutput($sformatf("vec%0d", i + 1), vecs[i].eReq, vecs[i].eAddr,
                  vecs[i].eG0, vecs[i].eG1, vecs[i].eRv0, vecs[i].eRv1,
                  vecs[i].eErr0, vecs[i].eErr1, vecs[i].eBusy, vecs[i].data);
    end

    // Grant m0 so the last winner becomes m0, then reset mid-transaction.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    #2;
    checkOutput("preReset", 1'b1, 32'h100, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h55555555, 1'b0);
    #2;
    checkOutput("midReset", 1'b1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h55555555);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    #2;
    checkOutput("postReset0", 1'b1, 32'h100, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    #2;
    checkOutput("postReset1", 1'b1, 32'h200, 0, 1, 0, 0, 0, 0, 1, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h66666666, 1'b0);
    #2;
    checkOutput("postRsp0", 1'b0, 32'h0, 0, 0, 1, 0, 0, 0, 1, 32'h66666666);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h77777777, 1'b1);
    #2;
    checkOutput("postRsp1", 1'b0, 32'h0, 0, 0, 0, 1, 0, 1, 1, 32'h77777777);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    checkOutput("postIdle", 1'b0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
